// File: rtl/sync_evt_pkg.sv
// Shared constants and helpers for the synchronous event scheduler.
package sync_evt_pkg;

  localparam int DEFAULT_N = 4;

  // Index width needed to name one of n requesters (never narrower than one bit).
  function automatic int idw_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_evt_sched_rr_pick.sv
// Round-robin picker: first set pending bit at or after ptr, wrapping N-1 -> 0.
module rr_pick
  import sync_evt_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int IDW = idw_for(N)
) (
  input  logic [N-1:0]   pend,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] winner
);

  int idx;

  // Scan from the farthest offset down to offset 0 so the nearest candidate is written last and wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (pend[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/sync_evt_sched.sv
// Rising-edge event scheduler: per-requester pending flags, round-robin single-slot output, sticky overflow.
module sync_evt_sched
  import sync_evt_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int IDW = idw_for(N)
) (
  input  logic           clki,
  input  logic           rst,
  input  logic [N-1:0]   req_sync_i,
  output logic           evt_valid_o,
  output logic [IDW-1:0] evt_id_o,
  input  logic           evt_ready_i,
  output logic [N-1:0]   pend_o,
  output logic [N-1:0]   ovf_o,
  input  logic [N-1:0]   clr_ovf_i
);

  logic [N-1:0]   prev;
  logic [N-1:0]   pend;
  logic [N-1:0]   ovf;
  logic [IDW-1:0] ptr;
  logic [N-1:0]   req_edge;
  logic           found;
  logic [IDW-1:0] winner;
  logic           slot_free;
  logic           load;
  logic [N-1:0]   load_mask;
  logic [N-1:0]   ovf_set;
  logic [IDW-1:0] ptr_next;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .pend   (pend),
    .ptr    (ptr),
    .found  (found),
    .winner (winner)
  );

  // Derive edges, the slot load decision and the per-bit pend/overflow updates from registered state.
  always_comb begin
    req_edge  = req_sync_i & ~prev;
    slot_free = ~evt_valid_o | evt_ready_i;
    load      = slot_free & found;
    load_mask = '0;
    if (load) load_mask[winner] = 1'b1;
    ovf_set   = req_edge & pend & ~load_mask;
    ptr_next  = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);
  end

  // Edge history, pending flags and sticky overflow; prev resets high so levels held through reset are not events.
  always_ff @(posedge clki) begin
    if (rst) begin
      prev <= '1;
      pend <= '0;
      ovf  <= '0;
    end else begin
      prev <= req_sync_i;
      pend <= (pend & ~load_mask) | req_edge;
      ovf  <= (ovf & ~clr_ovf_i) | ovf_set;
    end
  end

  // Output slot and round-robin pointer; id holds its last value once the slot empties.
  always_ff @(posedge clki) begin
    if (rst) begin
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      ptr         <= '0;
    end else if (load) begin
      evt_valid_o <= 1'b1;
      evt_id_o    <= winner;
      ptr         <= ptr_next;
    end else if (evt_valid_o && evt_ready_i) begin
      evt_valid_o <= 1'b0;
    end
  end

  assign pend_o = pend;
  assign ovf_o  = ovf;

endmodule

// File: tb/tb_sync_evt_sched.sv
// Self-checking bench for sync_evt_sched (N=4): directed scenarios plus randomized traffic against a reference model.
module tb_sync_evt_sched;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clki = 1'b0;
  logic           rst;
  logic [N-1:0]   req_sync_i;
  logic           evt_valid_o;
  logic [IDW-1:0] evt_id_o;
  logic           evt_ready_i;
  logic [N-1:0]   pend_o;
  logic [N-1:0]   ovf_o;
  logic [N-1:0]   clr_ovf_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit [N-1:0] m_prev  = '1;
  bit [N-1:0] m_pend  = '0;
  bit [N-1:0] m_ovf   = '0;
  bit         m_valid = 1'b0;
  int         m_id    = 0;
  int         m_ptr   = 0;

  int         grants[$];
  logic [N-1:0] ovf_seen;

  sync_evt_sched #(.N(N), .IDW(IDW)) dut (
    .clki        (clki),
    .rst         (rst),
    .req_sync_i  (req_sync_i),
    .evt_valid_o (evt_valid_o),
    .evt_id_o    (evt_id_o),
    .evt_ready_i (evt_ready_i),
    .pend_o      (pend_o),
    .ovf_o       (ovf_o),
    .clr_ovf_i   (clr_ovf_i)
  );

  // Free-running clock.
  always #5 clki = ~clki;

  // One comparison: counts it, passes or reports.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock: rising edges queue events, the slot takes the next pending
  // requester in circular order starting at the pointer, and a rise on an already-waiting requester overflows.
  task automatic model_step(input bit [N-1:0] req, input bit rdy, input bit [N-1:0] clr, input bit r);
    int  win;
    bit  take;
    bit  rose;
    bit  kept;
    if (r) begin
      m_prev = '1; m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_id = 0; m_ptr = 0;
      return;
    end
    win = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (win < 0 && m_pend[j]) win = j;
    end
    take = (win >= 0) && (!m_valid || rdy);
    for (int i = 0; i < N; i++) begin
      rose = req[i] && !m_prev[i];
      kept = m_pend[i] && !(take && win == i);
      if (rose && kept) m_ovf[i] = 1'b1;
      else if (clr[i]) m_ovf[i] = 1'b0;
      m_pend[i] = kept || rose;
    end
    if (take) begin
      m_valid = 1'b1;
      m_id    = win;
      m_ptr   = (win + 1) % N;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_prev = req;
  endtask

  // Drive one cycle of inputs, log completed handshakes, advance the model and compare all outputs.
  task automatic apply_stimulus(input logic [N-1:0] req, input logic rdy, input logic [N-1:0] clr, input logic r);
    req_sync_i  = req;
    evt_ready_i = rdy;
    clr_ovf_i   = clr;
    rst         = r;
    if (!r && evt_valid_o === 1'b1 && rdy) grants.push_back(int'(evt_id_o));
    @(posedge clki);
    model_step(req, rdy, clr, r);
    #1;
    check_output("valid", evt_valid_o, m_valid);
    check_output("id", evt_id_o, m_id);
    check_output("pend", pend_o, m_pend);
    check_output("ovf", ovf_o, m_ovf);
    ovf_seen = ovf_seen | ovf_o;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int exp_ids[3];
    logic [N-1:0] rq;
    ovf_seen    = '0;
    rst         = 1'b1;
    req_sync_i  = '0;
    evt_ready_i = 1'b0;
    clr_ovf_i   = '0;

    $display("[TB] reset state");
    apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b1);
    apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b1);
    check_output("rst_valid", evt_valid_o, 0);
    check_output("rst_id", evt_id_o, 0);
    check_output("rst_pend", pend_o, 0);
    check_output("rst_ovf", ovf_o, 0);

    $display("[TB] single event latency");
    apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(4'b0100, 1'b1, 4'b0000, 1'b0);
    check_output("lat_pend", pend_o, 4'b0100);
    check_output("lat_valid0", evt_valid_o, 0);
    apply_stimulus(4'b0100, 1'b1, 4'b0000, 1'b0);
    check_output("lat_valid1", evt_valid_o, 1);
    check_output("lat_id", evt_id_o, 2);
    apply_stimulus(4'b0100, 1'b1, 4'b0000, 1'b0);
    check_output("lat_drop", evt_valid_o, 0);
    check_output("lat_idhold", evt_id_o, 2);

    $display("[TB] simultaneous edges, back-to-back drain");
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b1);
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b1011, 1'b0, 4'b0000, 1'b0);
    check_output("b2b_pend", pend_o, 4'b1011);
    apply_stimulus(4'b1011, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b1011, 1'b0, 4'b0000, 1'b0);
    check_output("b2b_hold_valid", evt_valid_o, 1);
    check_output("b2b_hold_id", evt_id_o, 0);
    grants.delete();
    apply_stimulus(4'b1011, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(4'b1011, 1'b1, 4'b0000, 1'b0);
    check_output("b2b_valid", evt_valid_o, 1);
    apply_stimulus(4'b1011, 1'b1, 4'b0000, 1'b0);
    check_output("b2b_end", evt_valid_o, 0);
    exp_ids = '{0, 1, 3};
    check_output("b2b_count", grants.size(), 3);
    for (int k = 0; k < 3; k++)
      check_output($sformatf("b2b_grant%0d", k), (grants.size() > k) ? grants[k] : -1, exp_ids[k]);
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b0110, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b0110, 1'b0, 4'b0000, 1'b0);
    check_output("ptr_wrapped", evt_id_o, 1);
    for (int k = 0; k < 3; k++) apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b0);

    $display("[TB] overflow and clear");
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b1);
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b0010, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b0010, 1'b0, 4'b0000, 1'b0);
    check_output("ovf_inslot_pend", pend_o, 4'b0010);
    check_output("ovf_inslot_ovf", ovf_o, 0);
    check_output("ovf_inslot_id", evt_id_o, 1);
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b0010, 1'b0, 4'b0000, 1'b0);
    check_output("ovf_set", ovf_o, 4'b0010);
    check_output("ovf_pend_kept", pend_o, 4'b0010);
    apply_stimulus(4'b0000, 1'b0, 4'b0010, 1'b0);
    check_output("ovf_clear", ovf_o, 0);
    apply_stimulus(4'b0010, 1'b0, 4'b0010, 1'b0);
    check_output("ovf_set_wins", ovf_o, 4'b0010);
    apply_stimulus(4'b0000, 1'b0, 4'b0010, 1'b0);
    check_output("ovf_clear2", ovf_o, 0);
    apply_stimulus(4'b0010, 1'b1, 4'b0000, 1'b0);
    check_output("loadedge_pend", pend_o, 4'b0010);
    check_output("loadedge_ovf", ovf_o, 0);
    check_output("loadedge_valid", evt_valid_o, 1);
    apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b0);
    check_output("loadedge_done", evt_valid_o, 0);

    $display("[TB] level held through reset");
    apply_stimulus(4'b1000, 1'b1, 4'b0000, 1'b1);
    apply_stimulus(4'b1000, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(4'b1000, 1'b1, 4'b0000, 1'b0);
    check_output("held_pend", pend_o, 0);
    check_output("held_valid", evt_valid_o, 0);
    apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b0);
    grants.delete();
    for (int k = 0; k < 4; k++) apply_stimulus(4'b1000, 1'b1, 4'b0000, 1'b0);
    check_output("held_count", grants.size(), 1);
    check_output("held_id", (grants.size() > 0) ? grants[0] : -1, 3);

    $display("[TB] reset mid-operation");
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b1);
    apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b0001, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(4'b1010, 1'b0, 4'b0000, 1'b0);
    check_output("mid_valid", evt_valid_o, 1);
    check_output("mid_pend", pend_o, 4'b1010);
    grants.delete();
    apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b1);
    check_output("mid_rst_valid", evt_valid_o, 0);
    check_output("mid_rst_id", evt_id_o, 0);
    check_output("mid_rst_pend", pend_o, 0);
    check_output("mid_rst_ovf", ovf_o, 0);
    for (int k = 0; k < 3; k++) apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b0);
    check_output("mid_no_replay", evt_valid_o, 0);
    check_output("mid_no_grants", grants.size(), 0);

    $display("[TB] fairness");
    apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b1);
    apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b0);
    grants.delete();
    ovf_seen = '0;
    for (int c = 0; c < 40; c++) begin
      rq = ((c / 2) % 2 == 1) ? 4'b1111 : 4'b0000;
      apply_stimulus(rq, 1'b1, 4'b0000, 1'b0);
    end
    check_output("fair_count", grants.size() >= 16, 1);
    for (int k = 0; k < 16; k++)
      check_output($sformatf("fair_grant%0d", k), (grants.size() > k) ? grants[k] : -1, k % 4);
    check_output("fair_no_ovf", ovf_seen, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] r_req;
      logic [N-1:0] r_clr;
      logic         r_rdy;
      logic         r_rst;
      r_req = N'($urandom);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      r_rst = ($urandom_range(0, 63) == 0);
      apply_stimulus(r_req, r_rdy, r_clr, r_rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_evt_sched.md
SYNC_EVT_SCHED -- requirements
Module: sync_evt_sched

Interface
REQ-001 Parameter: N, default 4, number of requesters (2..32).
REQ-002 Parameter: IDW, default 2, requester-index width; SHALL equal ceil(log2(N)).
REQ-003 clki  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_sync_i  input  N  per-requester levels, already synchronized to clki upstream.
REQ-006 evt_valid_o  output  1  event slot holds an event.
REQ-007 evt_id_o  output  IDW  index of the requester owning the held event.
REQ-008 evt_ready_i  input  1  consumer accepts the held event.
REQ-009 pend_o  output  N  per-requester pending-event flags.
REQ-010 ovf_o  output  N  per-requester sticky overflow flags.
REQ-011 clr_ovf_i  input  N  per-bit clear of ovf_o.

Function
REQ-012 SHALL register req_sync_i into prev each cycle; edge[i] = req_sync_i[i] & ~prev[i] (0->1 transitions only; 1->0 ignored).
REQ-013 edge[i] SHALL set pend[i] on the next clock.
REQ-014 Output slot empty or handshaking (evt_valid_o & evt_ready_i) with any pend set: SHALL load the round-robin winner into evt_id_o, assert evt_valid_o, clear that pend bit, same clock.
REQ-015 Round-robin search SHALL start at pointer ptr, ascending with wrap N-1 -> 0; on each load ptr SHALL become (winner+1) mod N.
REQ-016 evt_valid_o and evt_id_o SHALL hold stable while evt_valid_o=1 and evt_ready_i=0.
REQ-017 Handshake with no pend set: evt_valid_o SHALL drop next clock.
REQ-018 Handshake with pend set: new event SHALL load with no bubble (back-to-back valid).
REQ-019 Latency: req_sync_i[i] 0 in cycle c-1, 1 in cycle c, slot free, no other pend -> pend_o[i]=1 in c+1, evt_valid_o=1 with evt_id_o=i in c+2.
REQ-020 edge[i] while pend[i]=1 and bit i not loaded that clock: pend[i] SHALL stay 1 and ovf[i] SHALL set.
REQ-021 edge[i] on the clock pend[i] loads into the slot: pend[i] SHALL remain 1 (new event kept), no overflow.
REQ-022 Event for requester i already in the slot SHALL NOT block a new pend[i]; no overflow.
REQ-023 clr_ovf_i[i] SHALL clear ovf[i] next clock; a simultaneous overflow event SHALL win (ovf[i] stays 1).
REQ-024 evt_id_o SHALL be a don't-care when evt_valid_o=0, but SHALL be held at last value (no toggling).

Reset
REQ-025 rst=1 at a clock edge: pend, ovf, evt_valid_o, evt_id_o, ptr SHALL become 0.
REQ-026 rst SHALL load prev with all ones, so a level already high at reset release generates no event.
REQ-027 Reset mid-operation SHALL discard the held event and all pending events; no handshake completes on the reset clock.
REQ-028 First edge SHALL be detectable on the second clock after rst deasserts (input low one cycle, then high).

Structure
REQ-029 Package sync_evt_pkg SHALL hold the IDW-from-N clog2 function and the default-N constant.
REQ-030 One combinational sub-module rr_pick SHALL take pend (N) and ptr (IDW) and return found (1) and winner (IDW).
REQ-031 All state SHALL live in sync_evt_sched; no latches; no combinational path from evt_ready_i to evt_valid_o or evt_id_o.

Verification
REQ-032 N=4, ready=1, pulse req[2] 0->1 at cycle 10 -> pend_o[2]=1 at 11, evt_valid_o=1 with id=2 at 12, valid low at 13.
REQ-033 ready=0, edges on req[0],req[1],req[3] same cycle, then ready=1 -> ids 0,1,3 back-to-back, ptr ends at 0.
REQ-034 ready=0, two edges on req[1] 4 cycles apart (first loaded into slot) -> second sets pend[1], ovf_o[1]=0; third edge -> ovf_o[1]=1; clr_ovf_i[1] pulse -> ovf_o[1]=0 next cycle.
REQ-035 req[3] held high through rst release -> no event; drop then raise -> one event, id=3.
REQ-036 Assert rst while evt_valid_o=1 and pend_o=4'b1010 -> next cycle all outputs 0; no event replayed.
REQ-037 Fairness: all four requesters toggled continuously, ready=1 -> grant order 0,1,2,3,0,... and no ovf_o bit ever sets.
